// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared types and constants for the instruction-fetch sequencer and the
//   general-purpose register used as its program counter.
//   - state_e        : fetch FSM states
//   - CLR/LOAD/DEC/INC : register function-select encodings
//   - LO/HI          : IR half-select encodings
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    VALID    = 2'd3
  } state_e;

  localparam logic [1:0] CLR  = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] DEC  = 2'b10;
  localparam logic [1:0] INC  = 2'b11;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

endpackage

// File: rtl/fetch_sequencer_register.sv
// register
//   N-bit register with enable and a 2-bit function select.
//   Ports:
//     clk_i    : clock, updates on posedge
//     e_i      : enable; register holds when low
//     funsel_i : CLR (zero), LOAD (data_i), DEC (q-1), INC (q+1)
//     data_i   : load data
//     q_o      : current register value
module register
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk_i,
  input  logic         e_i,
  input  logic [1:0]   funsel_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (e_i) begin
      case (funsel_i)
        CLR:     q_q <= '0;
        LOAD:    q_q <= data_i;
        DEC:     q_q <= q_q - 1'b1;
        default: q_q <= q_q + 1'b1;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch control stage. Owns the PC, issues byte reads to the
//   8-bit instruction memory and drives the 16-bit IR load controls so each
//   instruction is assembled low byte first, then high byte. Hands complete
//   instructions to decode via instr_valid/instr_ready and accepts redirects.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     fetch_en              : permit a new fetch from IDLE / after handshake
//     mem_addr, mem_rd      : memory byte address (= PC) and read request
//     mem_ack               : memory data valid this cycle
//     ir_enable, ir_funsel, ir_lh : IR load controls
//     instr_valid, instr_ready    : decode handshake
//     pc_load, pc_target    : PC redirect
//     pc_out                : current PC
//     fetch_err             : sticky ack-timeout fault
//   Build option: define FETCH_TIMEOUT_EN to enable the ack-timeout watchdog;
//   otherwise the block waits for ack indefinitely and fetch_err is 0.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  output logic              ir_enable,
  output logic [1:0]        ir_funsel,
  output logic              ir_lh,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_err
);

  state_e            state_q, state_d;
  logic              in_fetch;
  logic              timeout_hit;
  logic              pc_e;
  logic [1:0]        pc_funsel;
  logic [ADDR_W-1:0] pc_q;

  assign in_fetch = (state_q == FETCH_LO) || (state_q == FETCH_HI);

  // PC: reset, redirects and post-ack increments all go through the
  // register's function select rather than a separate reset path.
  register #(.N(ADDR_W)) u_pc (
    .clk_i    (clk),
    .e_i      (pc_e),
    .funsel_i (pc_funsel),
    .data_i   (pc_target),
    .q_o      (pc_q)
  );

  always_comb begin
    pc_e      = 1'b0;
    pc_funsel = LOAD;
    if (rst) begin
      pc_e      = 1'b1;
      pc_funsel = CLR;
    end else begin
      case (state_q)
        IDLE: begin
          if (pc_load) begin
            pc_e      = 1'b1;
            pc_funsel = LOAD;
          end
        end
        FETCH_LO, FETCH_HI: begin
          if (mem_ack) begin
            pc_e      = 1'b1;
            pc_funsel = INC;
          end
        end
        VALID: begin
          if (instr_ready && pc_load) begin
            pc_e      = 1'b1;
            pc_funsel = LOAD;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Counter holds 0..TIMEOUT-1; the fault fires on the cycle it would
  // reach TIMEOUT, i.e. after TIMEOUT cycles of unanswered mem_rd.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;

  assign timeout_hit = in_fetch && !mem_ack && (wait_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (in_fetch) begin
      wait_d = wait_q + 1'b1;
    end
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!pc_load && fetch_en) state_d = FETCH_LO;
      end
      FETCH_LO: begin
        if (mem_ack)          state_d = FETCH_HI;
        else if (timeout_hit) state_d = IDLE;
      end
      FETCH_HI: begin
        if (mem_ack)          state_d = VALID;
        else if (timeout_hit) state_d = IDLE;
      end
      VALID: begin
        if (instr_ready) state_d = fetch_en ? FETCH_LO : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Outputs are forced to their reset values while rst is asserted so a
  // reset landing mid-fetch cannot write the IR in that cycle.
  always_comb begin
    mem_rd      = !rst && in_fetch;
    ir_enable   = !rst && in_fetch && mem_ack;
    ir_funsel   = rst ? CLR : LOAD;
    ir_lh       = (!rst && (state_q == FETCH_HI)) ? HI : LO;
    instr_valid = !rst && (state_q == VALID);
  end

  assign mem_addr = pc_q;
  assign pc_out   = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch_en = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_ack;
  logic       ir_enable;
  logic [1:0] ir_funsel;
  logic       ir_lh;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       pc_load = 1'b0;
  logic [7:0] pc_target = 8'h00;
  logic [7:0] pc_out;
  logic       fetch_err;

  int tests_run = 0;
  int tests_failed = 0;

  // memory / ack model
  logic [7:0] mem [256];
  logic       ack_en = 1'b1;
  logic       force_ack = 1'b0;
  int         ack_delay = 0;
  int         wcnt = 0;

  // IR model fed by the DUT's load controls
  logic [15:0] ir_q = 16'h0000;
  int          ir_writes = 0;

  always #5 clk = ~clk;

  assign mem_ack = force_ack | (ack_en & mem_rd & (wcnt >= ack_delay));

  always @(posedge clk) begin
    if (!mem_rd || mem_ack) wcnt <= 0;
    else                    wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (ir_enable) begin
      ir_writes <= ir_writes + 1;
      if (ir_funsel == 2'b01) begin
        if (ir_lh) ir_q[15:8] <= mem[mem_addr];
        else       ir_q[7:0]  <= mem[mem_addr];
      end else if (ir_funsel == 2'b00) begin
        ir_q <= 16'h0000;
      end
    end
  end

  fetch_sequencer #(.ADDR_W(8), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_ack     (mem_ack),
    .ir_enable   (ir_enable),
    .ir_funsel   (ir_funsel),
    .ir_lh       (ir_lh),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .pc_out      (pc_out),
    .fetch_err   (fetch_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    tests_run++; if (mem_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_rd got %b exp 0", mem_rd); end
    tests_run++; if (ir_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_ir_enable got %b exp 0", ir_enable); end
    tests_run++; if (ir_funsel !== 2'b00) begin tests_failed++; $display("FAIL reset_ir_funsel got %b exp 00", ir_funsel); end
    tests_run++; if (ir_lh !== 1'b0) begin tests_failed++; $display("FAIL reset_ir_lh got %b exp 0", ir_lh); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
    tests_run++; if (pc_out !== 8'h00) begin tests_failed++; $display("FAIL reset_pc got %h exp 00", pc_out); end
    tests_run++; if (fetch_err !== 1'b0) begin tests_failed++; $display("FAIL reset_fetch_err got %b exp 0", fetch_err); end
    rst = 1'b0;
    #1;
    tests_run++; if (ir_funsel !== 2'b01) begin tests_failed++; $display("FAIL idle_ir_funsel got %b exp 01", ir_funsel); end
  endtask

  task automatic test_zero_wait;
    mem[8'h00] = 8'h34;
    mem[8'h01] = 8'h12;
    ack_en = 1'b1; ack_delay = 0; instr_ready = 1'b0;
    fetch_en = 1'b1;
    tick(); // FETCH_LO
    tests_run++; if (mem_rd !== 1'b1) begin tests_failed++; $display("FAIL zw_lo_mem_rd got %b exp 1", mem_rd); end
    tests_run++; if (mem_addr !== 8'h00) begin tests_failed++; $display("FAIL zw_lo_addr got %h exp 00", mem_addr); end
    tests_run++; if ({ir_enable, ir_funsel, ir_lh} !== 4'b1010) begin tests_failed++; $display("FAIL zw_lo_irctl got %b exp 1010", {ir_enable, ir_funsel, ir_lh}); end
    fetch_en = 1'b0; // must not abort the fetch
    tick(); // FETCH_HI
    tests_run++; if (mem_addr !== 8'h01) begin tests_failed++; $display("FAIL zw_hi_addr got %h exp 01", mem_addr); end
    tests_run++; if ({ir_enable, ir_funsel, ir_lh} !== 4'b1011) begin tests_failed++; $display("FAIL zw_hi_irctl got %b exp 1011", {ir_enable, ir_funsel, ir_lh}); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL zw_hi_valid got %b exp 0", instr_valid); end
    tick(); // VALID, cycle 3
    tests_run++; if (instr_valid !== 1'b1) begin tests_failed++; $display("FAIL zw_valid got %b exp 1", instr_valid); end
    tests_run++; if (ir_q !== 16'h1234) begin tests_failed++; $display("FAIL zw_ir got %h exp 1234", ir_q); end
    tests_run++; if (pc_out !== 8'h02) begin tests_failed++; $display("FAIL zw_pc got %h exp 02", pc_out); end
    tests_run++; if ({mem_rd, ir_enable} !== 2'b00) begin tests_failed++; $display("FAIL zw_valid_rd_en got %b exp 00", {mem_rd, ir_enable}); end
  endtask

  task automatic test_back_pressure;
    int w0;
    w0 = ir_writes;
    instr_ready = 1'b0;
    force_ack = 1'b1;   // stray ack in VALID
    pc_load = 1'b1;     // redirect without ready
    pc_target = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++; if ({instr_valid, mem_rd, ir_enable} !== 3'b100) begin tests_failed++; $display("FAIL bp_hold[%0d] got %b exp 100", i, {instr_valid, mem_rd, ir_enable}); end
      tests_run++; if (pc_out !== 8'h02) begin tests_failed++; $display("FAIL bp_pc[%0d] got %h exp 02", i, pc_out); end
    end
    tests_run++; if (ir_writes !== w0) begin tests_failed++; $display("FAIL bp_ir_writes got %0d exp %0d", ir_writes, w0); end
    force_ack = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic test_redirect;
    mem[8'h40] = 8'h78;
    mem[8'h41] = 8'h56;
    instr_ready = 1'b1; pc_load = 1'b1; pc_target = 8'h40; fetch_en = 1'b1;
    tick(); // FETCH_LO at redirect target
    tests_run++; if (mem_addr !== 8'h40) begin tests_failed++; $display("FAIL rd_addr got %h exp 40", mem_addr); end
    instr_ready = 1'b0; fetch_en = 1'b0;
    pc_target = 8'h80; // pc_load mid-fetch must be ignored
    tick();
    tests_run++; if (mem_addr !== 8'h41) begin tests_failed++; $display("FAIL rd_hi_addr got %h exp 41", mem_addr); end
    pc_load = 1'b0;
    tick();
    tests_run++; if (ir_q !== 16'h5678) begin tests_failed++; $display("FAIL rd_ir got %h exp 5678", ir_q); end
    tests_run++; if (pc_out !== 8'h42) begin tests_failed++; $display("FAIL rd_pc got %h exp 42", pc_out); end
    instr_ready = 1'b1;
    tick(); // IDLE
    tests_run++; if ({instr_valid, mem_rd} !== 2'b00) begin tests_failed++; $display("FAIL rd_idle got %b exp 00", {instr_valid, mem_rd}); end
    instr_ready = 1'b0;
  endtask

  task automatic test_wait_states;
    int cycles;
    int pulses;
    logic [1:0] lh_seq;
    mem[8'h10] = 8'hEF;
    mem[8'h11] = 8'hBE;
    pc_load = 1'b1; pc_target = 8'h10; fetch_en = 1'b1;
    tick(); // redirect wins, stays IDLE
    tests_run++; if (pc_out !== 8'h10) begin tests_failed++; $display("FAIL ws_pc_load got %h exp 10", pc_out); end
    tests_run++; if (mem_rd !== 1'b0) begin tests_failed++; $display("FAIL ws_idle_rd got %b exp 0", mem_rd); end
    pc_load = 1'b0; ack_delay = 3;
    tick(); // FETCH_LO
    fetch_en = 1'b0;
    cycles = 0; pulses = 0; lh_seq = 2'b00;
    while (!instr_valid && cycles < 30) begin
      tests_run++; if (mem_rd !== 1'b1) begin tests_failed++; $display("FAIL ws_rd[%0d] got %b exp 1", cycles, mem_rd); end
      tests_run++; if (mem_addr !== ((pulses == 0) ? 8'h10 : 8'h11)) begin tests_failed++; $display("FAIL ws_addr[%0d] got %h", cycles, mem_addr); end
      if (ir_enable) begin
        if (pulses < 2) lh_seq[pulses] = ir_lh;
        pulses++;
      end
      cycles++;
      tick();
    end
    tests_run++; if (cycles !== 8) begin tests_failed++; $display("FAIL ws_cycles got %0d exp 8", cycles); end
    tests_run++; if (pulses !== 2) begin tests_failed++; $display("FAIL ws_pulses got %0d exp 2", pulses); end
    tests_run++; if (lh_seq !== 2'b10) begin tests_failed++; $display("FAIL ws_lh_order got %b exp 10", lh_seq); end
    tests_run++; if (ir_q !== 16'hBEEF) begin tests_failed++; $display("FAIL ws_ir got %h exp beef", ir_q); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    ack_delay = 0;
  endtask

  task automatic test_wrap;
    mem[8'hFF] = 8'hCD;
    mem[8'h00] = 8'hAB;
    pc_load = 1'b1; pc_target = 8'hFF;
    tick();
    pc_load = 1'b0; fetch_en = 1'b1;
    tick();
    tests_run++; if (mem_addr !== 8'hFF) begin tests_failed++; $display("FAIL wrap_lo_addr got %h exp ff", mem_addr); end
    fetch_en = 1'b0;
    tick();
    tests_run++; if (mem_addr !== 8'h00) begin tests_failed++; $display("FAIL wrap_hi_addr got %h exp 00", mem_addr); end
    tick();
    tests_run++; if (ir_q !== 16'hABCD) begin tests_failed++; $display("FAIL wrap_ir got %h exp abcd", ir_q); end
    tests_run++; if (pc_out !== 8'h01) begin tests_failed++; $display("FAIL wrap_pc got %h exp 01", pc_out); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid_fetch;
    int w0;
    ack_en = 1'b0; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tests_run++; if (mem_rd !== 1'b1) begin tests_failed++; $display("FAIL rmf_rd_before got %b exp 1", mem_rd); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_ack = 1'b1; // late ack after reset
    w0 = ir_writes;
    #1;
    tests_run++; if ({mem_rd, ir_enable, instr_valid} !== 3'b000) begin tests_failed++; $display("FAIL rmf_outs got %b exp 000", {mem_rd, ir_enable, instr_valid}); end
    tick();
    tests_run++; if (pc_out !== 8'h00) begin tests_failed++; $display("FAIL rmf_pc got %h exp 00", pc_out); end
    tests_run++; if (ir_writes !== w0) begin tests_failed++; $display("FAIL rmf_ir_writes got %0d exp %0d", ir_writes, w0); end
    force_ack = 1'b0; ack_en = 1'b1;
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    pc_load = 1'b1; pc_target = 8'h20;
    tick();
    pc_load = 1'b0; ack_en = 1'b0; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    n = 0;
    while (mem_rd && n < 40) begin
      n++;
      tick();
    end
    tests_run++; if (n !== 15) begin tests_failed++; $display("FAIL to_cycles got %0d exp 15", n); end
    tests_run++; if (fetch_err !== 1'b1) begin tests_failed++; $display("FAIL to_err got %b exp 1", fetch_err); end
    tests_run++; if (pc_out !== 8'h20) begin tests_failed++; $display("FAIL to_pc got %h exp 20", pc_out); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL to_valid got %b exp 0", instr_valid); end
    ack_en = 1'b1; fetch_en = 1'b1;
    tick(); tick();
    fetch_en = 1'b0;
    tick();
    tests_run++; if ({instr_valid, fetch_err} !== 2'b11) begin tests_failed++; $display("FAIL to_sticky got %b exp 11", {instr_valid, fetch_err}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tests_run++; if (fetch_err !== 1'b0) begin tests_failed++; $display("FAIL to_clear got %b exp 0", fetch_err); end
  endtask
`else
  task automatic test_timeout;
    ack_en = 1'b0; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    repeat (30) tick();
    tests_run++; if ({mem_rd, fetch_err, instr_valid} !== 3'b100) begin tests_failed++; $display("FAIL nto_wait got %b exp 100", {mem_rd, fetch_err, instr_valid}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack_en = 1'b1;
    tick();
    tests_run++; if ({mem_rd, pc_out} !== 9'h000) begin tests_failed++; $display("FAIL nto_reset got %h exp 000", {mem_rd, pc_out}); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_zero_wait();
    test_back_pressure();
    test_redirect();
    test_wait_states();
    test_wrap();
    test_reset_mid_fetch();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch control stage sitting directly upstream of the 16-bit instruction register.
- Owns the program counter and issues byte reads to the 8-bit instruction memory.
- Generates the IR load controls (enable, funsel, lh) so each 16-bit instruction is assembled low byte first, then high byte.
- Presents a valid/ready handshake to the decode stage and accepts PC redirects (jumps) from it.

Parameters:
- ADDR_W, 8, program counter and memory address width.
- TIMEOUT, 15, cycles to wait for mem_ack before faulting; used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  allows a new fetch to start from IDLE or after a handshake.
- mem_addr  out  ADDR_W  byte address; always equals the current PC.
- mem_rd  out  1  read request; held high until mem_ack.
- mem_ack  in  1  memory data valid this cycle; the IR samples its data bus at this posedge.
- ir_enable  out  1  IR enable.
- ir_funsel  out  2  IR function select.
- ir_lh  out  1  IR half select: 0 = bits 7:0, 1 = bits 15:8.
- instr_valid  out  1  IR holds a complete instruction.
- instr_ready  in  1  decode stage accepts the instruction.
- pc_load  in  1  redirect request.
- pc_target  in  ADDR_W  redirect address.
- pc_out  out  ADDR_W  current PC.
- fetch_err  out  1  sticky timeout fault (constant 0 without the optional feature).

Behaviour:
- Reset: state IDLE, PC=0, mem_rd=0, ir_enable=0, ir_funsel=2'b00, ir_lh=0, instr_valid=0, fetch_err=0.
- States: IDLE, FETCH_LO, FETCH_HI, VALID.
- IDLE:
  - pc_load=1 → PC<=pc_target and stay in IDLE that cycle.
  - Otherwise fetch_en=1 → FETCH_LO.
- FETCH_LO:
  - mem_rd=1.
  - On mem_ack: ir_enable=1, ir_funsel=2'b01, ir_lh=0 (combinational, same cycle as ack); PC<=PC+1; next state FETCH_HI.
- FETCH_HI:
  - Same as FETCH_LO except ir_lh=1; next state VALID.
- VALID:
  - instr_valid=1; mem_rd=0; IR untouched.
  - Stay in VALID until instr_ready=1.
  - On handshake: if pc_load=1 then PC<=pc_target (redirect wins over sequential PC).
  - Then go to FETCH_LO if fetch_en=1, else IDLE.
- ir_enable=0 in every cycle except an ack cycle in FETCH_LO or FETCH_HI.
- Outside ack cycles, ir_funsel is driven 2'b01; it is 2'b00 only in reset.
- Latency: with mem_ack high in the same cycle as mem_rd, instr_valid rises 2 cycles after leaving IDLE. Throughput is one instruction per 3 cycles under continuous ready.
- mem_ack outside FETCH_LO/FETCH_HI is ignored.
- pc_load outside IDLE, or in VALID without instr_ready, is ignored.
- PC is modulo 2^ADDR_W: 8'hFF+1 → 8'h00. An instruction whose low byte is at FF takes its high byte from 00.
- fetch_en dropping mid-fetch does not abort; the current instruction completes.
- rst mid-fetch returns to the reset state next cycle. A later mem_ack is ignored.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH_LO/FETCH_HI and increments each cycle without ack.
  - If the counter reaches TIMEOUT: mem_rd drops, state → IDLE, fetch_err set.
  - fetch_err stays set until rst. PC is unchanged (the faulting address remains visible). IR is not written.
- Undefined: no counter; the block waits for ack indefinitely; fetch_err tied to 0.

Decomposition:
- Shared package:
  - state enum (IDLE, FETCH_LO, FETCH_HI, VALID).
  - IR funsel constants: CLR=2'b00, LOAD=2'b01, DEC=2'b10, INC=2'b11.
  - lh constants LO=0, HI=1.
- Sub-module: the existing register module, instantiated as register #(ADDR_W) for the PC.
  - funsel 01 with load mux on pc_target for redirect.
  - funsel 11 for increment.
  - funsel 00 on rst.
- The FSM stays in the top module.

Test Plan:
- Zero-wait fetch: rst then fetch_en=1, ack tied to mem_rd, memory[0]=34, memory[1]=12, instr_ready=1 → instr_valid on cycle 3; IR=16'h1234; PC=2.
- Wait states: ack delayed 3 cycles per byte → mem_rd held high throughout; mem_addr stable; ir_enable pulses exactly twice (lh=0, then lh=1).
- Back-pressure: instr_ready=0 for 5 cycles in VALID → instr_valid held; mem_rd=0; PC=2; no IR writes.
- Redirect: in VALID, instr_ready=1, pc_load=1, pc_target=8'h40 → next mem_addr=8'h40, not 8'h02.
- Wrap: pc_load to 8'hFF in IDLE; memory[FF]=CD, memory[00]=AB → IR=16'hABCD; PC=8'h01.
- Timeout (FETCH_TIMEOUT_EN): ack never asserted → after 15 cycles mem_rd=0, state IDLE, fetch_err=1, PC unchanged; fetch_err clears only on rst.
